// File: rtl/clock_domain_gen_if.sv
// Configuration and derived-clock bundle between the processor top level
// and the clock/reset generator.
interface clock_domain_gen_if #(
  parameter int NUM_CLKS  = 4,
  parameter int DIV_WIDTH = 4
);
  logic [NUM_CLKS*DIV_WIDTH-1:0] cfg_div;
  logic [NUM_CLKS-1:0]           cfg_inv;
  logic                          cfg_load;
  logic [NUM_CLKS-1:0]           clk_out;
  logic                          rst_out;
  logic                          ready;

  modport master (
    output cfg_div, cfg_inv, cfg_load,
    input  clk_out, rst_out, ready
  );

  modport slave (
    input  cfg_div, cfg_inv, cfg_load,
    output clk_out, rst_out, ready
  );
endinterface

// File: rtl/clock_domain_gen.sv
// Derived clock generator: per-channel divide/invert with phase-aligned
// restart, plus a downstream reset sequencer holding rst_out for RST_HOLD cycles.
module clock_domain_gen_ch #(
  parameter int DIV_WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 restart,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 inv,
  output logic                 clk
);
  logic [DIV_WIDTH-1:0] cnt, nxt;
  logic [DIV_WIDTH:0]   half;
  logic                 ph, divided;

  always_comb begin
    divided = (div > DIV_WIDTH'(1));
    // one extra bit so ceil(d/2) cannot overflow at the maximum ratio
    half    = ({1'b0, div} + (DIV_WIDTH+1)'(1)) >> 1;
    if (restart || cnt == div - DIV_WIDTH'(1)) nxt = '0;
    else                                        nxt = cnt + DIV_WIDTH'(1);
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      cnt <= '0;
      ph  <= 1'b0;
    end else if (divided) begin
      cnt <= nxt;
      ph  <= ({1'b0, nxt} < half);
    end
  end

  assign clk = divided ? (ph ^ inv) : (clock ^ inv);
endmodule

module clock_domain_gen #(
  parameter int NUM_CLKS  = 4,
  parameter int DIV_WIDTH = 4,
  parameter int RST_HOLD  = 8
) (
  input  logic               clock,
  input  logic               reset,
  clock_domain_gen_if.slave  bus
);
  localparam int RW = $clog2(RST_HOLD + 1);

  typedef enum logic [1:0] {S_RESET, S_SETTLE, S_RUN} state_t;

  state_t                              state;
  logic [RW-1:0]                       rcnt;
  logic                                rst_q, ready_q;
  logic [NUM_CLKS-1:0][DIV_WIDTH-1:0]  div_q;
  logic [NUM_CLKS-1:0]                 inv_q;
  logic [NUM_CLKS-1:0]                 clk_w;
  logic                                restart, load, clear;

  assign load  = bus.cfg_load & ~reset;
  assign clear = reset | bus.cfg_load;

  // restart marks the first counting cycle after a clear, where every
  // divided channel enters count 0 with its phase high
  always_ff @(posedge clock) begin
    if (reset) begin
      div_q   <= {NUM_CLKS{DIV_WIDTH'(1)}};
      inv_q   <= '0;
      restart <= 1'b1;
    end else begin
      restart <= load;
      if (load) begin
        div_q <= bus.cfg_div;
        inv_q <= bus.cfg_inv;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_RESET;
      rcnt    <= '0;
      rst_q   <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      case (state)
        S_RESET: begin
          state <= S_SETTLE;
          rcnt  <= '0;
        end
        S_SETTLE: begin
          if (bus.cfg_load) begin
            rcnt <= '0;
          end else if (rcnt == RW'(RST_HOLD - 1)) begin
            state   <= S_RUN;
            rst_q   <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            rcnt <= rcnt + RW'(1);
          end
        end
        S_RUN: begin
          if (bus.cfg_load) begin
            state   <= S_SETTLE;
            rcnt    <= '0;
            rst_q   <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state   <= S_RESET;
          rst_q   <= 1'b1;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CLKS; i++) begin : g_ch
    clock_domain_gen_ch #(.DIV_WIDTH(DIV_WIDTH)) u_ch (
      .clock   (clock),
      .clear   (clear),
      .restart (restart),
      .div     (div_q[i]),
      .inv     (inv_q[i]),
      .clk     (clk_w[i])
    );
  end

  assign bus.clk_out = clk_w;
  assign bus.rst_out = rst_q;
  assign bus.ready   = ready_q;
endmodule

// File: tb/tb_clock_domain_gen.sv
// Directed bench for clock_domain_gen: expected outputs for each edge are
// queued when stimulus is applied and popped as the DUT outputs are sampled.
module tb_clock_domain_gen;
  localparam int NUM_CLKS  = 4;
  localparam int DIV_WIDTH = 4;
  localparam int RST_HOLD  = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;

  clock_domain_gen_if #(.NUM_CLKS(NUM_CLKS), .DIV_WIDTH(DIV_WIDTH)) bus ();

  clock_domain_gen #(.NUM_CLKS(NUM_CLKS), .DIV_WIDTH(DIV_WIDTH), .RST_HOLD(RST_HOLD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    string               tag;
    logic [NUM_CLKS-1:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // reference state: active config, edges since last clear, edges into settle
  int   m_div[NUM_CLKS];
  logic m_inv[NUM_CLKS];
  int   k  = 0;
  int   sc = -1;

  function automatic logic [NUM_CLKS-1:0] exp_clk(input logic hi);
    logic [NUM_CLKS-1:0] r;
    logic v;
    r = '0;
    for (int i = 0; i < NUM_CLKS; i++) begin
      if (m_div[i] < 2)  v = hi;
      else if (k == 0)   v = 1'b0;
      else               v = (((k - 1) % m_div[i]) < ((m_div[i] + 1) / 2));
      r[i] = v ^ m_inv[i];
    end
    return r;
  endfunction

  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < NUM_CLKS; i++) begin
        m_div[i] = 1;
        m_inv[i] = 1'b0;
      end
      k  = 0;
      sc = -1;
    end else if (bus.cfg_load) begin
      for (int i = 0; i < NUM_CLKS; i++) begin
        m_div[i] = int'(bus.cfg_div[i*DIV_WIDTH +: DIV_WIDTH]);
        m_inv[i] = bus.cfg_inv[i];
      end
      k  = 0;
      sc = 0;
    end else begin
      k++;
      sc++;
    end
  endtask

  task automatic check(input logic [NUM_CLKS-1:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty got %b exp queued entry", obs);
    end else begin
      e = sb.pop_front();
      checks++;
      assert (obs === e.exp)
      else begin
        errors++;
        $error("FAIL %s got %b exp %b", e.tag, obs, e.exp);
      end
    end
  endtask

  // one master cycle: queue expectations for the coming edge, then sample
  // just after the rising edge and again in the low half of the cycle
  task automatic cyc();
    logic rst_e;
    model_edge();
    rst_e = (sc < RST_HOLD);
    sb.push_back('{"rst_out", NUM_CLKS'(rst_e)});
    sb.push_back('{"ready",   NUM_CLKS'(!rst_e)});
    sb.push_back('{"clk_hi",  exp_clk(1'b1)});
    sb.push_back('{"clk_lo",  exp_clk(1'b0)});
    @(posedge clock);
    #2;
    check(NUM_CLKS'(bus.rst_out));
    check(NUM_CLKS'(bus.ready));
    check(bus.clk_out);
    @(negedge clock);
    #2;
    check(bus.clk_out);
  endtask

  initial begin
    bus.cfg_div  = '0;
    bus.cfg_inv  = '0;
    bus.cfg_load = 1'b0;
    reset        = 1'b1;

    // reset with default pass-through config, then the settle interval
    repeat (3) cyc();
    reset = 1'b0;
    repeat (12) cyc();

    // ch3..ch0 = 4,3,2,1
    bus.cfg_div  = {4'd4, 4'd3, 4'd2, 4'd1};
    bus.cfg_inv  = 4'b0000;
    bus.cfg_load = 1'b1;
    cyc();
    bus.cfg_load = 1'b0;
    repeat (14) cyc();

    // config inputs change without a load: no effect
    bus.cfg_div = {4'd5, 4'd5, 4'd5, 4'd5};
    bus.cfg_inv = 4'b1111;
    repeat (4) cyc();

    // ch0,ch1 pass-through, ch2,ch3 divide-by-2, ch0 and ch2 inverted
    bus.cfg_div  = {4'd2, 4'd2, 4'd1, 4'd1};
    bus.cfg_inv  = 4'b0101;
    bus.cfg_load = 1'b1;
    cyc();
    bus.cfg_load = 1'b0;
    repeat (12) cyc();

    // reload in RUN, second reload three cycles later extends settle
    bus.cfg_div  = {4'd3, 4'd3, 4'd3, 4'd3};
    bus.cfg_inv  = 4'b0000;
    bus.cfg_load = 1'b1;
    cyc();
    bus.cfg_load = 1'b0;
    repeat (2) cyc();
    bus.cfg_div  = {4'd15, 4'd15, 4'd3, 4'd2};
    bus.cfg_inv  = 4'b1000;
    bus.cfg_load = 1'b1;
    cyc();
    bus.cfg_load = 1'b0;
    repeat (34) cyc();

    // reset and load together: reset wins, config not captured
    reset        = 1'b1;
    bus.cfg_div  = {4'd3, 4'd3, 4'd3, 4'd3};
    bus.cfg_inv  = 4'b1111;
    bus.cfg_load = 1'b1;
    cyc();
    reset        = 1'b0;
    bus.cfg_load = 1'b0;
    repeat (11) cyc();

    // load held for several cycles restarts alignment every cycle
    bus.cfg_div  = {4'd4, 4'd2, 4'd3, 4'd5};
    bus.cfg_inv  = 4'b0010;
    bus.cfg_load = 1'b1;
    repeat (3) cyc();
    bus.cfg_load = 1'b0;
    repeat (12) cyc();

    if (sb.size() != 0) begin
      errors++;
      $error("FAIL sb_leftover got %0d exp 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/clock_domain_gen.md
Name: clock_domain_gen

Overview:
- Parametrised clock/reset generator for the processor top level.
- Derives NUM_CLKS per-domain clocks (imem, dmem, processor, regfile, ...) from the master clock. Each clock has a programmable divide ratio and inversion.
- Sequences a held downstream reset so memories and the processor leave reset together after a settle interval.
- Configuration may be reloaded at runtime. A reload forces a phase-aligned restart of all domains.

Parameters:
- NUM_CLKS, 4, number of derived clock channels.
- DIV_WIDTH, 4, width of each channel's divide-ratio field.
- RST_HOLD, 8, master-clock cycles rst_out stays high after reset or reload; must be >= 1.

Ports:
- clock  input  1  master clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- cfg_div  input  NUM_CLKS*DIV_WIDTH  per-channel divide ratio; channel i uses bits [i*DIV_WIDTH +: DIV_WIDTH].
- cfg_inv  input  NUM_CLKS  per-channel output inversion.
- cfg_load  input  1  single-cycle strobe; captures cfg_div and cfg_inv.
- clk_out  output  NUM_CLKS  derived clocks.
- rst_out  output  1  held reset for downstream blocks (active-high).
- ready  output  1  high when in RUN.

Behaviour:
- One clock; reset is synchronous and active-high (ports clock, reset).
- Shadow registers:
  - div_q[i] and inv_q[i] hold the active configuration.
  - Reset values: div_q = 1 and inv_q = 0 for every channel.
  - When cfg_load = 1 and reset = 0, cfg_div and cfg_inv are captured at that edge. The new values take effect from the next cycle.
- Channel modes for d = div_q[i]:
  - d = 0 or 1 (pass-through): clk_out[i] = clock XOR inv_q[i]. This path is combinational and its counter is unused.
  - d >= 2 (divided):
    - A DIV_WIDTH-bit counter cnt[i] counts 0..d-1 and wraps to 0.
    - Registered phase ph[i] = 1 when the next count value is < ceil(d/2), else 0.
    - clk_out[i] = ph[i] XOR inv_q[i].
    - Period is d master cycles; high time is ceil(d/2) cycles.
- Alignment:
  - Reset and every accepted cfg_load clear all cnt to 0 and all ph to 0.
  - Counting resumes in the same cycle for every channel, so all divided channels are phase-aligned.
  - In the first counting cycle cnt = 0 and ph = 1, so every divided output rises together one cycle after the clear.
- Sequencer states, with rcnt as a ceil(log2(RST_HOLD+1))-bit counter:
  - RESET: entered while reset = 1. Outputs rst_out = 1, ready = 0; counters and phases cleared. Goes to SETTLE on the first cycle with reset = 0, with rcnt = 0.
  - SETTLE: rst_out = 1, ready = 0; rcnt increments each cycle. Goes to RUN when rcnt reaches RST_HOLD-1, so rst_out is high for exactly RST_HOLD cycles after reset deasserts.
  - RUN: rst_out = 0, ready = 1. On cfg_load goes to SETTLE with rcnt = 0; rst_out rises on the next edge.
  - cfg_load in SETTLE: configuration is captured, counters realign and rcnt restarts at 0, so the settle interval is extended.
- Reset values: rst_out = 1, ready = 0, ph = 0. clk_out[i] follows clock for pass-through channels and is 0 for divided channels.
- Simultaneous events:
  - reset dominates cfg_load; configuration is not captured.
  - cfg_load held high for several cycles acts as a reload on every cycle.
- Reset mid-operation: all state returns to reset values on that edge, including shadow config (back to pass-through).
- Changing cfg_div or cfg_inv without cfg_load has no effect.

Test Plan:
- Reset, RST_HOLD = 8, default config -> rst_out high for exactly 8 cycles after reset falls, then ready = 1; all clk_out track clock.
- cfg_load with cfg_div = {4,3,2,1} (ch3..ch0) and cfg_inv = 0 -> ch3 period 4 with 2 high/2 low; ch2 period 3 with 2 high/1 low; ch1 period 2; ch0 = clock; ch1..ch3 rise together one cycle after load; rst_out pulses 8 cycles.
- cfg_inv = 4'b0101 with div {1,1,2,2} -> ch0 = ~clock, ch1 = clock, ch2 = inverted divide-by-2 starting low, ch3 normal divide-by-2.
- cfg_load in RUN, then a second cfg_load 3 cycles later -> rst_out stays high until 8 cycles after the second load; second config active.
- reset and cfg_load asserted in the same cycle -> config not captured; after release div_q = 1 and inv_q = 0.
- DIV_WIDTH = 4 with d = 15 -> cnt wraps 14 to 0, period 15, 8 high/7 low; no overflow.
